// File: rtl/register_uart_tx.sv
// register_uart_tx
// Serial transmitter peripheral on the core's register bus. The core writes
// characters into a TX FIFO, and a shifter sends each one as a frame on tx:
// a start bit, DATA_BITS data bits (LSB first) and one stop bit. The register
// window starts at BASE_INDEX:
//   +0 DATA    write: enqueue a character (dropped and overflow set if full)
//   +1 STATUS  read: {count, 4'b0, overflow, busy, empty, full}
//              write: bit3 = 1 clears overflow
//   +2 DIVIDER read/write: clocks per bit (a write of 0 is ignored)
// Ports:
//   clk                  single clock, rising edge
//   reset                asynchronous, active-high
//   register_index       register address from the core
//   register_read        read strobe
//   register_write       write strobe, one cycle per access
//   register_write_value write data
//   register_read_value  combinational read data, 0 when not selected
//   tx                   serial output, idle high
//   tx_idle              FIFO empty and shifter idle
module register_uart_tx #(
  parameter int BASE_INDEX   = 0,
  parameter int FIFO_DEPTH   = 8,
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  register_index,
  input  logic        register_read,
  input  logic        register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  output logic        tx,
  output logic        tx_idle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0]       IDX_DATA   = 7'(BASE_INDEX);
  localparam logic [6:0]       IDX_STATUS = 7'(BASE_INDEX + 1);
  localparam logic [6:0]       IDX_DIV    = 7'(BASE_INDEX + 2);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [3:0]       LAST_BIT   = 4'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic [CNT_W-1:0]     count_s;
  logic                 overflow_r;
  logic [15:0]          divider_r;

  // Shifter state
  state_t               state_r;
  state_t               state_s;
  logic [15:0]          div_lat_r;
  logic [15:0]          div_lat_s;
  logic [15:0]          baud_cnt_r;
  logic [15:0]          baud_cnt_s;
  logic [3:0]           bit_cnt_r;
  logic [3:0]           bit_cnt_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_s;
  logic                 tx_r;
  logic                 tx_s;
  logic                 tx_idle_r;
  logic                 tx_idle_s;

  // Decode and handshake signals
  logic                 sel_data_s;
  logic                 sel_status_s;
  logic                 sel_div_s;
  logic                 wr_data_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 busy_s;
  logic                 bit_end_s;
  logic [DATA_BITS-1:0] head_s;

  assign sel_data_s   = (register_index == IDX_DATA);
  assign sel_status_s = (register_index == IDX_STATUS);
  assign sel_div_s    = (register_index == IDX_DIV);
  assign wr_data_s    = register_write && sel_data_s;
  assign fifo_full_s  = (count_r == DEPTH_C);
  assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
  // The full test uses the pre-edge count, so a pop in the same cycle
  // does not rescue a write to a full FIFO.
  assign push_s       = wr_data_s && !fifo_full_s;
  assign busy_s       = (state_r != ST_IDLE);
  assign head_s       = mem_r[rd_ptr_r];
  // Last clock of the current bit period, using the divider latched at frame start
  assign bit_end_s    = (baud_cnt_r == (div_lat_r - 16'd1));

  assign tx      = tx_r;
  assign tx_idle = tx_idle_r;

  // Combinational read mux so several peripherals can be OR-ed together
  always_comb begin
    register_read_value = 16'h0000;
    if (register_read) begin
      if (sel_status_s) begin
        register_read_value = {8'(count_r), 4'h0, overflow_r, busy_s, fifo_empty_s, fifo_full_s};
      end else if (sel_div_s) begin
        register_read_value = divider_r;
      end else begin
        register_read_value = 16'h0000;
      end
    end else begin
      register_read_value = 16'h0000;
    end
  end

  // FIFO data storage (no reset needed, pointers define validity)
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= register_write_value[DATA_BITS-1:0];
    end
  end

  // Next FIFO occupancy from this cycle's push/pop
  always_comb begin
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_ONE;
      2'b01:   count_s = count_r - CNT_ONE;
      default: count_s = count_r;
    endcase
  end

  // FIFO pointers, count, sticky overflow and divider register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
      divider_r  <= 16'(CLKS_PER_BIT);
    end else begin
      count_r <= count_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (wr_data_s && fifo_full_s) begin
        overflow_r <= 1'b1;
      end else if (register_write && sel_status_s && register_write_value[3]) begin
        overflow_r <= 1'b0;
      end
      if (register_write && sel_div_s && (register_write_value != 16'h0000)) begin
        divider_r <= register_write_value;
      end
    end
  end

  // Shifter next-state, pop request and next serial output
  always_comb begin
    state_s    = state_r;
    div_lat_s  = div_lat_r;
    baud_cnt_s = baud_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    shift_s    = shift_r;
    pop_s      = 1'b0;
    tx_s       = 1'b1;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s      = 1'b1;
          shift_s    = head_s;
          div_lat_s  = divider_r;
          baud_cnt_s = 16'd0;
          bit_cnt_s  = 4'd0;
          state_s    = ST_START;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          baud_cnt_s = 16'd0;
          bit_cnt_s  = 4'd0;
          state_s    = ST_DATA;
        end else begin
          baud_cnt_s = baud_cnt_r + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          baud_cnt_s = 16'd0;
          shift_s    = {1'b0, shift_r[DATA_BITS-1:1]};
          if (bit_cnt_r == LAST_BIT) begin
            state_s   = ST_STOP;
          end else begin
            bit_cnt_s = bit_cnt_r + 4'd1;
          end
        end else begin
          baud_cnt_s = baud_cnt_r + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          baud_cnt_s = 16'd0;
          // Back-to-back frames: pop straight into the next start bit
          if (!fifo_empty_s) begin
            pop_s     = 1'b1;
            shift_s   = head_s;
            div_lat_s = divider_r;
            bit_cnt_s = 4'd0;
            state_s   = ST_START;
          end else begin
            state_s   = ST_IDLE;
          end
        end else begin
          baud_cnt_s = baud_cnt_r + 16'd1;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        baud_cnt_s = 16'd0;
      end
    endcase

    case (state_s)
      ST_IDLE:  tx_s = 1'b1;
      ST_START: tx_s = 1'b0;
      ST_DATA:  tx_s = shift_s[0];
      ST_STOP:  tx_s = 1'b1;
      default:  tx_s = 1'b1;
    endcase

    tx_idle_s = (count_s == {CNT_W{1'b0}}) && (state_s == ST_IDLE);
  end

  // Shifter registers and registered serial outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      div_lat_r  <= 16'(CLKS_PER_BIT);
      baud_cnt_r <= 16'd0;
      bit_cnt_r  <= 4'd0;
      shift_r    <= {DATA_BITS{1'b0}};
      tx_r       <= 1'b1;
      tx_idle_r  <= 1'b1;
    end else begin
      state_r    <= state_s;
      div_lat_r  <= div_lat_s;
      baud_cnt_r <= baud_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      tx_r       <= tx_s;
      tx_idle_r  <= tx_idle_s;
    end
  end

endmodule

// File: tb/tb_register_uart_tx.sv
// Self-checking bench for register_uart_tx (default parameters: base 0,
// depth 8, 8 data bits, reset divider 16). Inputs change on the falling
// edge and outputs are sampled on the falling edge, away from the active
// rising edge.
module tb_register_uart_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  register_index = 7'd0;
  logic        register_read = 1'b0;
  logic        register_write = 1'b0;
  logic [15:0] register_write_value = 16'h0000;
  logic [15:0] register_read_value;
  logic        tx;
  logic        tx_idle;

  int total = 0;
  int bad = 0;

  register_uart_tx #(
    .BASE_INDEX  (0),
    .FIFO_DEPTH  (8),
    .DATA_BITS   (8),
    .CLKS_PER_BIT(16)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .register_index      (register_index),
    .register_read       (register_read),
    .register_write      (register_write),
    .register_write_value(register_write_value),
    .register_read_value (register_read_value),
    .tx                  (tx),
    .tx_idle             (tx_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        do_wr;
    logic [6:0]  widx;
    logic [15:0] wval;
    logic        do_rd;
    logic [6:0]  ridx;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [11];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // Called at a falling edge; the write is sampled by the next rising edge
  // and the task returns at the falling edge after it.
  task automatic wr(input logic [6:0] idx, input logic [15:0] val);
    register_index       = idx;
    register_write_value = val;
    register_write       = 1'b1;
    @(negedge clk);
    register_write       = 1'b0;
  endtask

  task automatic rd(input logic [6:0] idx, output logic [15:0] val);
    register_index = idx;
    register_read  = 1'b1;
    #1;
    val            = register_read_value;
    register_read  = 1'b0;
  endtask

  // Checks a whole frame on tx, one falling-edge sample per clock. With
  // start_pos = 0 it first waits (bounded) for the start bit; otherwise the
  // first start_pos samples of the frame are already past.
  task automatic check_frame(input string name, input logic [7:0] ch, input int div,
                             input int start_pos, input int max_wait, output int waited);
    logic [9:0] bits;
    int         pos;
    int         first_bad;
    logic       bad_act;
    logic       bad_exp;
    bits      = {1'b1, ch, 1'b0};
    waited    = 0;
    first_bad = -1;
    bad_act   = 1'b0;
    bad_exp   = 1'b0;
    pos       = start_pos;
    if (start_pos == 0) begin
      do begin
        @(negedge clk);
        waited++;
      end while (tx !== 1'b0 && waited < max_wait);
      if (tx !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL %s_start: tx=%b after %0d clocks, required 0", name, tx, waited);
        return;
      end
      pos = 1;
    end
    for (int i = pos; i < 10 * div; i++) begin
      @(negedge clk);
      if (tx !== bits[i / div] && first_bad < 0) begin
        first_bad = i;
        bad_act   = tx;
        bad_exp   = bits[i / div];
      end
    end
    total++;
    if (first_bad >= 0) begin
      bad++;
      $display("FAIL %s_bits: clock %0d of frame tx=%b required %b", name, first_bad, bad_act, bad_exp);
    end
  endtask

  // tx must stay high and tx_idle stay set for n clocks
  task automatic check_quiet(input string name, input int n);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_idle !== 1'b1) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s: %0d of %0d clocks not idle, required 0", name, errs, n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rv;
    int          w;

    // Register access vectors applied right after reset (no DATA writes)
    vecs[0]  = '{1'b0, 7'd0, 16'h0000, 1'b1, 7'd1,   16'h0002};
    vecs[1]  = '{1'b0, 7'd0, 16'h0000, 1'b1, 7'd2,   16'h0010};
    vecs[2]  = '{1'b0, 7'd0, 16'h0000, 1'b0, 7'd1,   16'h0000};
    vecs[3]  = '{1'b0, 7'd0, 16'h0000, 1'b1, 7'd0,   16'h0000};
    vecs[4]  = '{1'b0, 7'd0, 16'h0000, 1'b1, 7'd3,   16'h0000};
    vecs[5]  = '{1'b0, 7'd0, 16'h0000, 1'b1, 7'd127, 16'h0000};
    vecs[6]  = '{1'b1, 7'd2, 16'h0007, 1'b1, 7'd2,   16'h0007};
    vecs[7]  = '{1'b1, 7'd2, 16'h0000, 1'b1, 7'd2,   16'h0007};
    vecs[8]  = '{1'b1, 7'd3, 16'h0001, 1'b1, 7'd2,   16'h0007};
    vecs[9]  = '{1'b1, 7'd1, 16'hFFFF, 1'b1, 7'd1,   16'h0002};
    vecs[10] = '{1'b1, 7'd2, 16'h0004, 1'b1, 7'd2,   16'h0004};

    // Reset state
    repeat (3) @(negedge clk);
    check1("reset_tx", tx, 1'b1);
    check1("reset_tx_idle", tx_idle, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check1("post_reset_tx", tx, 1'b1);
    check1("post_reset_tx_idle", tx_idle, 1'b1);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].widx, vecs[i].wval);
      register_index = vecs[i].ridx;
      register_read  = vecs[i].do_rd;
      #1;
      check16($sformatf("vec%0d_read", i), register_read_value, vecs[i].exp_rd);
      register_read  = 1'b0;
      @(negedge clk);
    end

    // Single frame, divider 4 (set by the last vector)
    wr(7'd0, 16'h0055);
    check1("single_tx_idle_busy", tx_idle, 1'b0);
    check_frame("single55", 8'h55, 4, 0, 20, w);
    check16("single55_wait", 16'(w), 16'd1);
    @(negedge clk);
    check1("single55_tx_idle_after", tx_idle, 1'b1);

    // Three back-to-back frames, divider 2
    wr(7'd2, 16'd2);
    wr(7'd0, 16'h0041);
    wr(7'd0, 16'h0042);
    wr(7'd0, 16'h0043);
    rd(7'd1, rv);
    check16("b2b_status", rv, 16'h0204);
    check_frame("b2b_41", 8'h41, 2, 2, 0, w);
    check_frame("b2b_42", 8'h42, 2, 0, 20, w);
    check16("b2b_42_gap", 16'(w), 16'd1);
    check_frame("b2b_43", 8'h43, 2, 0, 20, w);
    check16("b2b_43_gap", 16'(w), 16'd1);
    @(negedge clk);
    check1("b2b_tx_idle_after", tx_idle, 1'b1);

    // Overflow: ten writes, one popped, eight queued, the tenth dropped
    wr(7'd2, 16'd100);
    for (int k = 0; k < 10; k++) wr(7'd0, 16'(16'h0030 + k));
    rd(7'd1, rv);
    check16("ovf_status", rv, 16'h080D);
    wr(7'd1, 16'h0008);
    rd(7'd1, rv);
    check16("ovf_cleared_status", rv, 16'h0805);
    check_frame("ovf_f0", 8'h30, 100, 10, 0, w);
    for (int k = 1; k < 9; k++) begin
      check_frame($sformatf("ovf_f%0d", k), 8'(8'h30 + k), 100, 0, 200, w);
      check16($sformatf("ovf_f%0d_gap", k), 16'(w), 16'd1);
    end
    check_quiet("ovf_no_tenth_frame", 300);

    // Reset in the middle of the data bits of an all-zero character
    wr(7'd2, 16'd4);
    wr(7'd0, 16'h0000);
    wr(7'd0, 16'h0000);
    repeat (8) @(negedge clk);
    check1("pre_reset_tx_low", tx, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check1("async_reset_tx", tx, 1'b1);
    check1("async_reset_tx_idle", tx_idle, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    rd(7'd1, rv);
    check16("after_reset_status", rv, 16'h0002);
    rd(7'd2, rv);
    check16("after_reset_divider", rv, 16'h0010);
    check_quiet("after_reset_no_frame", 100);

    // Divider 0 ignored; divider change mid-frame applies to the next frame
    wr(7'd2, 16'd4);
    wr(7'd2, 16'd0);
    rd(7'd2, rv);
    check16("div_zero_ignored", rv, 16'h0004);
    wr(7'd0, 16'h000F);
    wr(7'd0, 16'h00F0);
    wr(7'd2, 16'd3);
    check_frame("div_old_0f", 8'h0F, 4, 2, 0, w);
    check_frame("div_new_f0", 8'hF0, 3, 0, 20, w);
    check16("div_new_gap", 16'(w), 16'd1);
    rd(7'd2, rv);
    check16("div_readback_3", rv, 16'h0003);
    @(negedge clk);
    check1("final_tx_idle", tx_idle, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
